ex3_to_bcd_packer: RTL and testbench



---
 rtl/ex3_pkg.sv | 11 +
 rtl/ex3_digit_dec.sv | 15 +
 rtl/ex3_to_bcd_packer.sv | 109 ++++++++++
 tb/tb_ex3_to_bcd_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ex3_pkg.sv
// Shared constants and state type for the Excess-3 decode/pack path.
package ex3_pkg;

  localparam logic [3:0] EX3_OFFSET  = 4'd3;
  localparam logic [3:0] EX3_MIN     = 4'd3;
  localparam logic [3:0] EX3_MAX     = 4'd12;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {COLLECT, EMIT} state_e;

endpackage

// File: rtl/ex3_digit_dec.sv
// Combinational single-digit Excess-3 to BCD decoder; invalid codes map to BCD_INVALID.
module ex3_digit_dec
  import ex3_pkg::*;
(
  input  logic [3:0] ex3,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    err = (ex3 < EX3_MIN) || (ex3 > EX3_MAX);
    bcd = err ? BCD_INVALID : (ex3 - EX3_OFFSET);
  end

endmodule

// File: rtl/ex3_to_bcd_packer.sv
// Packs DIGITS serially received Excess-3 digits into one BCD word on a valid/ready port.
// Define EX3_ERR_MASK_EN to add the per-nibble out_err_mask port.
module ex3_to_bcd_packer
  import ex3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_ex3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err
`ifdef EX3_ERR_MASK_EN
  ,
  output logic [DIGITS-1:0]     out_err_mask
`endif
);

  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIGITS - 1);

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  err_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic [3:0]            dec_bcd;
  logic                  dec_err;
  logic                  digit_xfer;
  logic                  word_xfer;

  ex3_digit_dec u_dec (
    .ex3 (in_ex3),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  // Handshakes use the registered ready/valid, so no input reaches an output combinationally.
  assign digit_xfer = in_valid && in_ready_q;
  assign word_xfer  = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      bcd_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          in_ready_q <= 1'b1;
          if (digit_xfer) begin
            bcd_q <= {bcd_q[4*DIGITS-5:0], dec_bcd};
            err_q <= err_q | dec_err;
            if (cnt_q == CntLast) begin
              cnt_q       <= '0;
              state_q     <= EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (word_xfer) begin
            state_q     <= COLLECT;
            bcd_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

`ifdef EX3_ERR_MASK_EN
  logic [DIGITS-1:0] mask_q;

  // Flags travel with their nibbles so bit i always describes nibble i.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else if (state_q == COLLECT && digit_xfer) begin
      mask_q <= {mask_q[DIGITS-2:0], dec_err};
    end else if (state_q == EMIT && word_xfer) begin
      mask_q <= '0;
    end
  end

  assign out_err_mask = mask_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = bcd_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ex3_to_bcd_packer.sv
// Scoreboard bench for ex3_to_bcd_packer with DIGITS=4; mask checked when EX3_ERR_MASK_EN is defined.
module tb_ex3_to_bcd_packer;

  typedef struct packed {
    logic [15:0] bcd;
    logic        err;
    logic [3:0]  mask;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ex3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic        out_err;
`ifdef EX3_ERR_MASK_EN
  logic [3:0]  out_err_mask;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ex3_to_bcd_packer #(.DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ex3       (in_ex3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err      (out_err)
`ifdef EX3_ERR_MASK_EN
    ,
    .out_err_mask (out_err_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] bcd, input logic err, input logic [3:0] mask);
    exp_t e;
    e.bcd  = bcd;
    e.err  = err;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic send_digit(input logic [3:0] d);
    int n;
    in_valid = 1'b1;
    in_ex3   = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected 1 for digit %h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every word transfer pops one expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %h expected none", out_bcd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word_bcd", 32'(out_bcd), 32'(e.bcd));
        chk("word_err", 32'(out_err), 32'(e.err));
`ifdef EX3_ERR_MASK_EN
        chk("word_mask", 32'(out_err_mask), 32'(e.mask));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int idx;
    int n;

    rst = 1'b1;
    in_valid = 1'b0;
    in_ex3 = 4'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
`ifdef EX3_ERR_MASK_EN
    chk("rst_out_mask", 32'(out_err_mask), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Basic word, valid for exactly one cycle.
    push(16'h0189, 1'b0, 4'b0000);
    send_digit(4'h3); send_digit(4'h4); send_digit(4'hB); send_digit(4'hC);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", 32'(out_valid), 32'd0);

    // One invalid code in nibble 2.
    push(16'h2F34, 1'b1, 4'b0100);
    send_digit(4'h5); send_digit(4'h0); send_digit(4'h6); send_digit(4'h7);
    @(posedge clk);
    #1;

    // Backpressure with in_valid held high.
    out_ready = 1'b0;
    push(16'h0001, 1'b0, 4'b0000);
    send_digit(4'h3); send_digit(4'h3); send_digit(4'h3); send_digit(4'h4);
    in_valid = 1'b1;
    in_ex3   = 4'h9;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_bcd", 32'(out_bcd), 32'h0001);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(16'h6789, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    chk("post_xfer_ready", 32'(in_ready), 32'd1);
    chk("post_xfer_valid", 32'(out_valid), 32'd0);
    send_digit(4'h9); send_digit(4'hA); send_digit(4'hB); send_digit(4'hC);
    @(posedge clk);
    #1;

    // Bubbles on in_valid.
    push(16'h0123, 1'b0, 4'b0000);
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_ex3   = 4'(3 + idx);
      @(posedge clk);
      #1;
      if (pat[i]) idx++;
      if (i < 6) chk("early_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk("bubble_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-word discards the partial digits.
    send_digit(4'h7); send_digit(4'h8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_bcd", 32'(out_bcd), 32'd0);
    rst = 1'b0;
    push(16'h9999, 1'b0, 4'b0000);
    repeat (4) send_digit(4'hC);
    @(posedge clk);
    #1;

    // Sweep all sixteen codes.
    push(16'hFFF0, 1'b1, 4'b1110);
    send_digit(4'h0); send_digit(4'h1); send_digit(4'h2); send_digit(4'h3);
    push(16'h1234, 1'b0, 4'b0000);
    send_digit(4'h4); send_digit(4'h5); send_digit(4'h6); send_digit(4'h7);
    push(16'h5678, 1'b0, 4'b0000);
    send_digit(4'h8); send_digit(4'h9); send_digit(4'hA); send_digit(4'hB);
    push(16'h9FFF, 1'b1, 4'b0111);
    send_digit(4'hC); send_digit(4'hD); send_digit(4'hE); send_digit(4'hF);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
